// File: rtl/cond_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cond_unit: NZCV flag register, condition evaluation and strobe gating.   |
// | Optional counters: COND_PERF_EN.  Rev 1.0                                |
// +--------------------------------------------------------------------------+
module cond_unit
`ifdef COND_PERF_EN
  #(
    parameter int CNT_W = 16
  )
`endif
  (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       VecW,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       VecWrite,
    output logic       CondEx,
    output logic [3:0] Flags
`ifdef COND_PERF_EN
    ,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
`endif
  );

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [1:0] flag_write;
  logic       cond_ex;
  logic       n_f, z_f, c_f, v_f;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {2{cond_ex}};

  always_comb begin
    flags_d = flags_q;
    if (reset) begin
      flags_d = 4'b0000;
    end else begin
      if (flag_write[1]) flags_d[3:2] = ALUFlags[3:2];
      if (flag_write[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    flags_q <= flags_d;
  end

  // Reset suppresses every architectural side effect but not the evaluation.
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS  & cond_ex & ~reset;
  assign RegWrite = RegW & cond_ex & ~reset;
  assign MemWrite = MemW & cond_ex & ~reset;
  assign VecWrite = VecW & cond_ex & ~reset;
  assign Flags    = flags_q;

`ifdef COND_PERF_EN
  logic [CNT_W-1:0] exec_count_q;
  logic [CNT_W-1:0] exec_count_d;
  logic [CNT_W-1:0] squash_count_q;
  logic [CNT_W-1:0] squash_count_d;

  always_comb begin
    exec_count_d   = exec_count_q;
    squash_count_d = squash_count_q;
    if (reset) begin
      exec_count_d   = '0;
      squash_count_d = '0;
    end else if (cond_ex) begin
      if (exec_count_q != {CNT_W{1'b1}}) exec_count_d = exec_count_q + 1'b1;
    end else begin
      if (squash_count_q != {CNT_W{1'b1}}) squash_count_d = squash_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    exec_count_q   <= exec_count_d;
    squash_count_q <= squash_count_d;
  end

  assign ExecCount   = exec_count_q;
  assign SquashCount = squash_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage directly downstream of the instruction decoder in the single-cycle ARM datapath. Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. Gates the decoder's raw write and branch strobes into the final enables seen by the register file, data memory, vector register file and PC mux. Updates the flags from the ALU under control of the decoder's two-bit FlagW.

## Interface
- CNT_W, 16: width of the performance counters; present only with COND_PERF_EN.
- clk  input  1  processor clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  current ALU result flags {N,Z,C,V}.
- FlagW  input  2  decoder flag-write request; [1] = N,Z group, [0] = C,V group.
- PCS  input  1  decoder PC-write request (branch, or write to R15).
- RegW  input  1  decoder register-file write request.
- MemW  input  1  decoder memory write request.
- VecW  input  1  decoder vector register write request.
- PCSrc  output  1  gated PC-source select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- VecWrite  output  1  gated vector register write enable.
- CondEx  output  1  condition passed for the current instruction.
- Flags  output  4  registered {N,Z,C,V}.
- ExecCount  output  CNT_W  instructions whose condition passed; present only with COND_PERF_EN.
- SquashCount  output  CNT_W  instructions whose condition failed; present only with COND_PERF_EN.

## Operation
- Flag register: 4 bits, reset to 4'b0000.
- CondEx is combinational from Cond and the registered Flags. It never uses ALUFlags of the same cycle.
- Condition codes:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 reserved, decided CondEx=0.
- Gating: PCSrc = PCS&CondEx, RegWrite = RegW&CondEx, MemWrite = MemW&CondEx, VecWrite = VecW&CondEx.
- Flag write enables: FlagWrite[1] = FlagW[1]&CondEx and FlagWrite[0] = FlagW[0]&CondEx.
  - FlagWrite[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagWrite[0] loads Flags[1:0] from ALUFlags[1:0].
  - The two groups update independently; a group not written holds its value.
- While reset is high:
  - PCSrc, RegWrite, MemWrite and VecWrite are forced to 0, regardless of inputs.
  - CondEx still reflects the evaluation.
- Reset asserted mid-program clears the flags on that edge. The flag write of that cycle is discarded.

## Timing
- Gated enables and CondEx: zero-cycle combinational path, valid in the same cycle as the decoder outputs.
- Flags: one-cycle latency. A flag-setting instruction in cycle n affects CondEx starting in cycle n+1.
- A flag-setting instruction whose own condition fails leaves the flags unchanged (self-gating).
- Flags readback shows the post-edge value. Reset value of every output after a reset edge with all inputs 0: all 0.

## Configuration
- COND_PERF_EN defined:
  - ExecCount and SquashCount are present.
  - Both reset to 0 synchronously.
  - Every non-reset cycle increments exactly one of them: ExecCount when CondEx=1, SquashCount when CondEx=0.
  - Each saturates at all-ones and holds there.
- COND_PERF_EN undefined:
  - The counters, their ports and CNT_W do not exist.
  - All other behaviour is identical.

## Test plan
- Reset then Cond=1110, RegW=1, MemW=1, VecW=1, PCS=1:
  - RegWrite=MemWrite=VecWrite=PCSrc=1.
  - With reset held high: all four are 0.
- Cond=1110, FlagW=11, ALUFlags=0100, one edge:
  - Flags=0100.
  - Next cycle, Cond=0000 (EQ): CondEx=1.
  - Next cycle, Cond=0001 (NE): CondEx=0 and RegWrite=0.
- Flags=1000, FlagW=01, ALUFlags=0111, one edge -> Flags=1011 (N,Z group held). Then Cond=1010 (GE) -> CondEx=1.
- Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111, one edge -> Flags stay 0000 (condition failed, no update).
- Cond=1111 with all requests high -> CondEx=0 and all gated outputs 0.
- COND_PERF_EN, CNT_W=4:
  - 20 cycles of Cond=1110 -> ExecCount=15 (saturated), SquashCount=0.
  - One cycle of Cond=1111 -> SquashCount=1.
